// File: rtl/sample_pkg.sv
// Shared types and default widths for the sample source and its read pipe.
package sample_pkg;
  localparam int SAMPLE_DATA_WIDTH = 11;
  localparam int SAMPLE_ADDR_WIDTH = 24;
  localparam int SAMPLE_LAT_W      = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_DONE  = 3'd4
  } sample_src_state_t;
endpackage

// File: rtl/sample_rd_pipe.sv
// Memory latency counter and sample capture register for the sample source.
module sample_rd_pipe
  import sample_pkg::*;
#(
  parameter int DATA_WIDTH  = SAMPLE_DATA_WIDTH,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_q
);
  logic [SAMPLE_LAT_W-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   data_d;

  // Counter at 1 marks the cycle in which the memory data is valid.
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    done   = 1'b0;
    if (abort) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d = SAMPLE_LAT_W'(MEM_LATENCY);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - SAMPLE_LAT_W'(1);
      if (cnt_q == SAMPLE_LAT_W'(1)) begin
        done   = ce;
        data_d = mem_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else if (ce) begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end
endmodule

// File: rtl/sample_source.sv
// Responder for the sample request/valid handshake: fetches record samples
// from a synchronous memory, owns the read pointer, and flags end-of-record.
module sample_source
  import sample_pkg::*;
#(
  parameter int DATA_WIDTH  = SAMPLE_DATA_WIDTH,
  parameter int ADDR_WIDTH  = SAMPLE_ADDR_WIDTH,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ce,
  input  logic                  i_sample_req,
  input  logic                  i_new_record,
  input  logic [ADDR_WIDTH-1:0] i_record_len,
  output logic                  o_mem_rd,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [DATA_WIDTH-1:0] o_sample,
  output logic                  o_sample_valid,
  output logic [ADDR_WIDTH-1:0] o_sample_idx,
  output logic                  o_record_end,
  output logic                  o_busy
);
  sample_src_state_t     state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                  mem_rd_q, mem_rd_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  sample_valid_q, sample_valid_d;
  logic [ADDR_WIDTH-1:0] sample_idx_q, sample_idx_d;
  logic                  record_end_q, record_end_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] ptr_cur;
  logic                  accept;
  logic                  pipe_start;
  logic                  pipe_done;
  logic [DATA_WIDTH-1:0] sample_q;

  sample_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_LATENCY(MEM_LATENCY)
  ) u_rd_pipe (
    .clk     (i_clk),
    .rst     (i_rst),
    .ce      (i_ce),
    .start   (pipe_start),
    .abort   (i_new_record),
    .mem_data(i_mem_data),
    .done    (pipe_done),
    .data_q  (sample_q)
  );

  always_comb begin
    state_d        = state_q;
    rd_ptr_d       = rd_ptr_q;
    mem_rd_d       = 1'b0;
    mem_addr_d     = mem_addr_q;
    sample_valid_d = 1'b0;
    sample_idx_d   = sample_idx_q;
    record_end_d   = record_end_q;
    ptr_cur        = rd_ptr_q;
    accept         = 1'b0;
    pipe_start     = 1'b0;

    unique case (state_q)
      S_IDLE: accept = i_sample_req;
      S_READ: begin
        pipe_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (pipe_done) begin
          state_d        = S_VALID;
          sample_valid_d = 1'b1;
          sample_idx_d   = rd_ptr_q;
        end
      end
      // The pointer advance is visible to a request accepted in this cycle.
      S_VALID: begin
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        ptr_cur  = rd_ptr_d;
        accept   = i_sample_req;
        state_d  = S_IDLE;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      if (ptr_cur < i_record_len) begin
        state_d    = S_READ;
        mem_rd_d   = 1'b1;
        mem_addr_d = ptr_cur;
      end else begin
        state_d      = S_DONE;
        record_end_d = 1'b1;
      end
    end

    // A new record abandons any read in flight and drops a coincident request.
    if (i_new_record) begin
      state_d        = S_IDLE;
      rd_ptr_d       = '0;
      record_end_d   = 1'b0;
      mem_rd_d       = 1'b0;
      mem_addr_d     = mem_addr_q;
      sample_valid_d = 1'b0;
      sample_idx_d   = sample_idx_q;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= S_IDLE;
      rd_ptr_q       <= '0;
      mem_rd_q       <= 1'b0;
      mem_addr_q     <= '0;
      sample_valid_q <= 1'b0;
      sample_idx_q   <= '0;
      record_end_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else if (i_ce) begin
      state_q        <= state_d;
      rd_ptr_q       <= rd_ptr_d;
      mem_rd_q       <= mem_rd_d;
      mem_addr_q     <= mem_addr_d;
      sample_valid_q <= sample_valid_d;
      sample_idx_q   <= sample_idx_d;
      record_end_q   <= record_end_d;
      busy_q         <= busy_d;
    end
  end

  assign o_mem_rd       = mem_rd_q;
  assign o_mem_addr     = mem_addr_q;
  assign o_sample       = sample_q;
  assign o_sample_valid = sample_valid_q;
  assign o_sample_idx   = sample_idx_q;
  assign o_record_end   = record_end_q;
  assign o_busy         = busy_q;
endmodule

// File: doc/sample_source.md
# sample_source

Responder side of the sample request/valid handshake used by the detection pipeline. On each single-cycle sample request it fetches the next sample of the current ECG record from a synchronous read memory, presents it with a one-cycle valid pulse, and advances its read address. It sits between the record memory and the sample-management front end, owns the record read pointer, and reports end-of-record.

## Interface
Parameters:
- DATA_WIDTH, 11, sample width in bits
- ADDR_WIDTH, 24, record address / length width
- MEM_LATENCY, 2, memory read latency in cycles from the o_mem_rd cycle to the i_mem_data valid cycle; legal range 1–7

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_ce  in  1  clock enable; low freezes the FSM, counters and all outputs
- i_sample_req  in  1  single-cycle request for the next sample
- i_new_record  in  1  single-cycle pulse; restarts at address 0
- i_record_len  in  ADDR_WIDTH  samples in the record; sampled when a request is accepted
- o_mem_rd  out  1  memory read strobe, one cycle per accepted request
- o_mem_addr  out  ADDR_WIDTH  read address; valid while o_mem_rd is high
- i_mem_data  in  DATA_WIDTH  memory read data
- o_sample  out  DATA_WIDTH  captured sample; holds until the next capture
- o_sample_valid  out  1  one-cycle pulse when o_sample is updated
- o_sample_idx  out  ADDR_WIDTH  address of the sample on o_sample
- o_record_end  out  1  level; high once the record is exhausted
- o_busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states are IDLE, READ, WAIT, VALID and DONE. All outputs are registered.
- Reset drives the state to IDLE, the read pointer rd_ptr to 0, and every output to 0.
- IDLE:
  - On i_sample_req with rd_ptr < i_record_len, go to READ.
  - On i_sample_req with rd_ptr ≥ i_record_len, go to DONE.
- READ: o_mem_rd=1 and o_mem_addr=rd_ptr for exactly one cycle. Load the latency counter with MEM_LATENCY, then go to WAIT.
- WAIT: decrement the latency counter. When it reaches 0, capture i_mem_data into o_sample and rd_ptr into o_sample_idx, then go to VALID.
- VALID: o_sample_valid=1 for one cycle and rd_ptr increments. The next state follows the same rules as IDLE, so a request arriving in the VALID cycle is accepted.
- DONE: o_record_end=1 and all requests are ignored. Only i_new_record or reset leaves DONE.
- i_new_record:
  - Valid in any state. Sets rd_ptr=0, clears o_record_end, and sends the FSM to IDLE.
  - Any read in flight is abandoned, with no o_sample_valid. o_sample and o_sample_idx keep their old values.
- A simultaneous i_new_record and i_sample_req: i_new_record wins and the request is dropped.
- A request arriving in READ or WAIT is ignored. The requester must not issue one there.
- i_record_len=0 causes the first request to go straight to DONE.
- rd_ptr does not wrap. It saturates at i_record_len, which is reached through DONE.
- A sample is 11-bit raw data with no sign handling.

## Timing
- Request accepted in cycle t (ce high throughout):
  - o_mem_rd is high at t+1.
  - Data is captured at t+1+MEM_LATENCY.
  - o_sample_valid is high at t+2+MEM_LATENCY.
  - With the default MEM_LATENCY=2, valid is at t+4.
- Back-to-back throughput is one sample per MEM_LATENCY+2 cycles.
- o_record_end rises one cycle after the request that finds rd_ptr ≥ i_record_len.
- i_ce low stalls the block cycle-for-cycle:
  - The latency counter does not advance, so the memory must hold its data while ce is low.
  - Pulse outputs stay as they were on the last enabled cycle. The requester and memory share i_ce.
- Reset in the middle of a read takes effect at the next edge. No valid pulse follows.

## Structure
- Shared package sample_pkg holds:
  - the state enum sample_src_state_t (3 bits)
  - the default localparams SAMPLE_DATA_WIDTH=11 and SAMPLE_ADDR_WIDTH=24
- One sub-module, sample_rd_pipe: the MEM_LATENCY-deep latency counter and capture register. It has inputs start, ce and rst, and outputs done and data_q.
- Top level: FSM, rd_ptr, and output registers.

## Test plan
- Reset with i_record_len=5, then a request at cycle 10 → o_mem_rd at 11 with addr 0. Memory returns 0x155 → o_sample=0x155, o_sample_idx=0, valid at 14.
- Five requests, each issued in the VALID cycle of the previous one → addresses 0..4, valid spaced 4 cycles apart. The 6th request → o_record_end=1 next cycle, no o_mem_rd.
- i_record_len=0, one request → o_record_end=1, no o_mem_rd or valid.
- i_new_record in the WAIT cycle of the read at address 3 → no valid pulse. The next request reads address 0.
- i_ce low for 3 cycles during WAIT → valid delayed by exactly 3 cycles, and o_sample still equals the memory data.
- Simultaneous i_new_record and i_sample_req while in DONE → o_record_end clears, no read issued. The next request reads address 0.
